// File: rtl/riscv_pkg.sv
// riscv_pkg: minimal ISA configuration shared by the trace infrastructure.
// Only the machine width is needed by the commit serializer.
package riscv;

    localparam int unsigned XLEN = 32;

endpackage : riscv

// File: rtl/rvfi_pkg.sv
// rvfi_pkg: RVFI commit record layout and the serializer state encoding.
//   rvfi_instr_t       - one retired (or trapped) instruction as reported
//                        by a commit port
//   serializer_state_e - termination FSM states (RUN, DRAIN, HALT)
package rvfi_pkg;

    localparam int unsigned XLEN  = riscv::XLEN;
    localparam int unsigned MASKW = XLEN / 8;

    typedef struct packed {
        logic             valid;
        logic [63:0]      order;
        logic [31:0]      insn;
        logic             trap;
        logic             halt;
        logic             intr;
        logic [1:0]       mode;
        logic [XLEN-1:0]  cause;
        logic [4:0]       rd_addr;
        logic [XLEN-1:0]  rd_wdata;
        logic [XLEN-1:0]  pc_rdata;
        logic [XLEN-1:0]  pc_wdata;
        logic [XLEN-1:0]  mem_addr;
        logic [MASKW-1:0] mem_rmask;
        logic [MASKW-1:0] mem_wmask;
        logic [XLEN-1:0]  mem_rdata;
        logic [XLEN-1:0]  mem_wdata;
    } rvfi_instr_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } serializer_state_e;

endpackage : rvfi_pkg

// File: rtl/rvfi_commit_serializer_if.sv
// rvfi_commit_serializer_if: valid/ready trace stream carrying one commit
// record plus the commit port it originated from.
//   valid - head record available       (producer -> consumer)
//   ready - consumer takes head         (consumer -> producer)
//   data  - head record                 (producer -> consumer)
//   port  - originating commit port     (producer -> consumer)
// Modports: master = producer side, slave = consumer side.
interface rvfi_commit_serializer_if #(
    parameter int unsigned PORT_W = 1
);
    import rvfi_pkg::*;

    logic              valid;
    logic              ready;
    rvfi_instr_t       data;
    logic [PORT_W-1:0] port;

    modport master (output valid, output data, output port, input ready);
    modport slave  (input valid, input data, input port, output ready);

endinterface : rvfi_commit_serializer_if

// File: rtl/rvfi_trace_fifo.sv
// rvfi_trace_fifo: multi-push, single-pop record buffer.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   push_mask_i   - per-port push request for this cycle
//   push_data_i   - per-port records
//   push_ok_o     - all requested pushes fit (pushes are all-or-nothing)
//   push_n_o      - number of requesting ports this cycle
//   count_o       - entries currently held
//   out_if        - head stream (master side)
// Pushed records are packed contiguously in ascending port order. The
// accept check credits a pop happening in the same cycle, so a full buffer
// still takes one push while the head is being consumed.
module rvfi_trace_fifo
    import rvfi_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PUSH_W = 2,
    parameter int unsigned PORT_W = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [PUSH_W-1:0]        push_mask_i,
    input  rvfi_instr_t              push_data_i [PUSH_W],
    output logic                     push_ok_o,
    output logic [$clog2(DEPTH):0]   push_n_o,
    output logic [$clog2(DEPTH):0]   count_o,
    rvfi_commit_serializer_if.master out_if
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    rvfi_instr_t       mem      [DEPTH];
    logic [PORT_W-1:0] port_mem [DEPTH];

    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] push_n;
    logic [PTR_W-1:0] slot [PUSH_W];
    logic             pop;
    logic             push_ok;

    // Each requesting port lands at wptr + (number of requesting ports below it).
    always_comb begin
        push_n = '0;
        for (int unsigned i = 0; i < PUSH_W; i++) begin
            slot[i] = wptr + push_n[PTR_W-1:0];
            if (push_mask_i[i]) begin
                push_n = push_n + CNT_W'(1);
            end
        end
        pop     = out_if.valid & out_if.ready;
        push_ok = ({1'b0, count} + {1'b0, push_n})
                  <= ((CNT_W+1)'(DEPTH) + (CNT_W+1)'(pop));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_W'(push_n);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            count <= count + (push_ok ? push_n : '0) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < PUSH_W; i++) begin
            if (push_ok && push_mask_i[i]) begin
                mem[slot[i]]      <= push_data_i[i];
                port_mem[slot[i]] <= PORT_W'(i);
            end
        end
    end

    assign out_if.valid = (count != '0);
    assign out_if.data  = mem[rptr];
    assign out_if.port  = port_mem[rptr];
    assign push_ok_o    = push_ok;
    assign push_n_o     = push_n;
    assign count_o      = count;

endmodule : rvfi_trace_fifo

// File: rtl/rvfi_commit_serializer.sv
// rvfi_commit_serializer: serializes up to NR_COMMIT_PORTS RVFI commit
// records per cycle into a single valid/ready trace stream and detects the
// tohost termination store.
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   rvfi_i         - commit records, port 0 oldest in program order
//   tohost_addr_i  - tohost address, 0 disables termination detection
//   trace_valid_o / trace_ready_i / trace_o / trace_port_o - head stream
//   overflow_o     - sticky, a cycle's pushes were dropped
//   dropped_cnt_o  - dropped records, saturating
//   halt_o         - termination seen and buffer drained
//   exit_code_o    - store data of the terminating store
module rvfi_commit_serializer
    import rvfi_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  rvfi_instr_t                                     rvfi_i [NR_COMMIT_PORTS],
    input  logic [riscv::XLEN-1:0]                          tohost_addr_i,
    output logic                                            trace_valid_o,
    input  logic                                            trace_ready_i,
    output rvfi_instr_t                                     trace_o,
    output logic [(NR_COMMIT_PORTS > 1 ? $clog2(NR_COMMIT_PORTS) : 1)-1:0] trace_port_o,
    output logic                                            overflow_o,
    output logic [31:0]                                     dropped_cnt_o,
    output logic                                            halt_o,
    output logic [riscv::XLEN-1:0]                          exit_code_o
);

    localparam int unsigned PORT_W = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    rvfi_commit_serializer_if #(.PORT_W(PORT_W)) trace_if ();

    serializer_state_e          state;
    logic [NR_COMMIT_PORTS-1:0] push_mask;
    logic                       push_ok;
    logic [CNT_W-1:0]           push_n;
    logic [CNT_W-1:0]           count;
    logic                       pop;
    logic                       term_hit;
    logic [32:0]                dropped_sum;

    // Once termination is seen, new commits are neither stored nor counted.
    always_comb begin
        push_mask = '0;
        if (state == RUN) begin
            for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
                push_mask[i] = rvfi_i[i].valid | rvfi_i[i].trap;
            end
        end
    end

    rvfi_trace_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .PUSH_W (NR_COMMIT_PORTS),
        .PORT_W (PORT_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_mask_i (push_mask),
        .push_data_i (rvfi_i),
        .push_ok_o   (push_ok),
        .push_n_o    (push_n),
        .count_o     (count),
        .out_if      (trace_if)
    );

    assign trace_if.ready = trace_ready_i;
    assign trace_valid_o  = trace_if.valid;
    assign trace_o        = trace_if.data;
    assign trace_port_o   = trace_if.port;

    assign pop = trace_if.valid & trace_if.ready;

    // Trap-only records carry valid=0 and therefore never terminate.
    assign term_hit = pop
                    && trace_if.data.valid
                    && (tohost_addr_i != '0)
                    && (trace_if.data.mem_addr == tohost_addr_i)
                    && (trace_if.data.mem_wmask != '0)
                    && trace_if.data.mem_wdata[0];

    assign dropped_sum = {1'b0, dropped_cnt_o} + 33'(push_n);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= RUN;
            overflow_o    <= 1'b0;
            dropped_cnt_o <= '0;
            halt_o        <= 1'b0;
            exit_code_o   <= '0;
        end else begin
            if ((push_mask != '0) && !push_ok) begin
                overflow_o    <= 1'b1;
                dropped_cnt_o <= dropped_sum[32] ? '1 : dropped_sum[31:0];
            end
            case (state)
                RUN: begin
                    if (term_hit) begin
                        exit_code_o <= trace_if.data.mem_wdata;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    // No pushes while draining, so count reaches 0 exactly
                    // when it is 0 already or its last entry pops now.
                    if ((count == '0) || ((count == CNT_W'(1)) && pop)) begin
                        state  <= HALT;
                        halt_o <= 1'b1;
                    end
                end
                HALT: begin
                    halt_o <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule : rvfi_commit_serializer

// File: tb/tb_rvfi_commit_serializer.sv
module tb_rvfi_commit_serializer;
    import rvfi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    rvfi_instr_t rvfi [2];
    logic [31:0] tohost;
    logic        overflow;
    logic [31:0] dropped;
    logic        halt;
    logic [31:0] exit_code;

    int checks = 0;
    int errors = 0;

    rvfi_commit_serializer_if #(.PORT_W(1)) tb_if ();

    always #5 clk = ~clk;

    rvfi_commit_serializer #(
        .NR_COMMIT_PORTS (2),
        .FIFO_DEPTH      (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rvfi_i        (rvfi),
        .tohost_addr_i (tohost),
        .trace_valid_o (tb_if.valid),
        .trace_ready_i (tb_if.ready),
        .trace_o       (tb_if.data),
        .trace_port_o  (tb_if.port),
        .overflow_o    (overflow),
        .dropped_cnt_o (dropped),
        .halt_o        (halt),
        .exit_code_o   (exit_code)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rvfi_instr_t mk(input logic v, input logic t, input logic [63:0] ord,
                                       input logic [31:0] addr, input logic [3:0] wmask,
                                       input logic [31:0] wdata);
        rvfi_instr_t r;
        r           = '0;
        r.valid     = v;
        r.trap      = t;
        r.order     = ord;
        r.mem_addr  = addr;
        r.mem_wmask = wmask;
        r.mem_wdata = wdata;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rvfi[0] = '0;
        rvfi[1] = '0;
    endtask

    task automatic push2(input logic [63:0] o0, input logic [63:0] o1);
        rvfi[0] = mk(1'b1, 1'b0, o0, 32'h0, 4'h0, 32'h0);
        rvfi[1] = mk(1'b1, 1'b0, o1, 32'h0, 4'h0, 32'h0);
        tick();
        idle();
    endtask

    int exp_order [8] = '{101, 102, 103, 104, 105, 106, 107, 200};

    initial begin
        idle();
        tohost      = '0;
        tb_if.ready = 1'b0;

        // Reset state
        tick();
        check("rst_valid", 64'(tb_if.valid), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_dropped", 64'(dropped), 64'd0);
        check("rst_halt", 64'(halt), 64'd0);
        check("rst_exit", 64'(exit_code), 64'd0);
        rst_n = 1'b1;
        tick();

        // Two ports in one cycle: port 0 first, then port 1
        tb_if.ready = 1'b1;
        push2(64'd10, 64'd11);
        check("dual_valid0", 64'(tb_if.valid), 64'd1);
        check("dual_order0", tb_if.data.order, 64'd10);
        check("dual_port0", 64'(tb_if.port), 64'd0);
        tick();
        check("dual_order1", tb_if.data.order, 64'd11);
        check("dual_port1", 64'(tb_if.port), 64'd1);
        tick();
        check("dual_empty", 64'(tb_if.valid), 64'd0);

        // Port 1 alone, held under backpressure
        tb_if.ready = 1'b0;
        rvfi[1] = mk(1'b1, 1'b0, 64'd20, 32'h0, 4'h0, 32'h0);
        tick();
        idle();
        check("p1_port", 64'(tb_if.port), 64'd1);
        check("p1_order", tb_if.data.order, 64'd20);
        tick();
        tick();
        check("p1_stable", tb_if.data.order, 64'd20);
        check("p1_stable_valid", 64'(tb_if.valid), 64'd1);
        tb_if.ready = 1'b1;
        tick();
        check("p1_drained", 64'(tb_if.valid), 64'd0);

        // Trap-only record is pushed
        rvfi[0] = mk(1'b0, 1'b1, 64'd30, 32'h0, 4'h0, 32'h0);
        tick();
        idle();
        check("trap_valid", 64'(tb_if.valid), 64'd1);
        check("trap_order", tb_if.data.order, 64'd30);
        tick();

        // Fill without ready: 4 cycles fit, 5th dropped
        tb_if.ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            push2(64'(100 + 2 * c), 64'(101 + 2 * c));
            if (c == 3) check("fill_no_ovf", 64'(overflow), 64'd0);
        end
        check("fill_ovf", 64'(overflow), 64'd1);
        check("fill_dropped", 64'(dropped), 64'd2);
        check("fill_head", tb_if.data.order, 64'd100);

        // Full buffer, pop and push in the same cycle
        tb_if.ready = 1'b1;
        rvfi[0] = mk(1'b1, 1'b0, 64'd200, 32'h0, 4'h0, 32'h0);
        tick();
        idle();
        check("full_pp_dropped", 64'(dropped), 64'd2);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain_valid%0d", k), 64'(tb_if.valid), 64'd1);
            check($sformatf("drain_order%0d", k), tb_if.data.order, 64'(exp_order[k]));
            tick();
        end
        check("drain_empty", 64'(tb_if.valid), 64'd0);

        // tohost = 0 disables termination
        tohost  = '0;
        rvfi[0] = mk(1'b1, 1'b0, 64'd40, 32'h0, 4'hf, 32'h1);
        tick();
        idle();
        check("noth_head", tb_if.data.order, 64'd40);
        tick();
        rvfi[0] = mk(1'b1, 1'b0, 64'd41, 32'h0, 4'h0, 32'h0);
        tick();
        idle();
        check("noth_halt", 64'(halt), 64'd0);
        check("noth_accept", tb_if.data.order, 64'd41);
        tick();

        // Trap-only and wdata[0]=0 stores to tohost do not terminate
        tohost  = 32'h8000_1000;
        rvfi[0] = mk(1'b0, 1'b1, 64'd42, 32'h8000_1000, 4'hf, 32'h1);
        tick();
        idle();
        tick();
        rvfi[0] = mk(1'b1, 1'b0, 64'd43, 32'h8000_1000, 4'hf, 32'h2);
        tick();
        idle();
        tick();
        rvfi[0] = mk(1'b1, 1'b0, 64'd44, 32'h0, 4'h0, 32'h0);
        tick();
        idle();
        check("noterm_accept", tb_if.data.order, 64'd44);
        check("noterm_halt", 64'(halt), 64'd0);
        check("noterm_exit", 64'(exit_code), 64'd0);
        tick();

        // Reset with 5 buffered entries
        tb_if.ready = 1'b0;
        push2(64'd50, 64'd51);
        push2(64'd52, 64'd53);
        rvfi[0] = mk(1'b1, 1'b0, 64'd54, 32'h0, 4'h0, 32'h0);
        tick();
        idle();
        check("pre_rst_head", tb_if.data.order, 64'd50);
        rst_n = 1'b0;
        tick();
        check("midrst_valid", 64'(tb_if.valid), 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        check("midrst_dropped", 64'(dropped), 64'd0);
        rst_n = 1'b1;
        rvfi[1] = mk(1'b1, 1'b0, 64'd60, 32'h0, 4'h0, 32'h0);
        tick();
        idle();
        check("postrst_head", tb_if.data.order, 64'd60);
        check("postrst_port", 64'(tb_if.port), 64'd1);
        tb_if.ready = 1'b1;
        tick();
        check("postrst_empty", 64'(tb_if.valid), 64'd0);

        // Terminating store with 3 entries behind it
        tb_if.ready = 1'b0;
        tohost  = 32'h8000_1000;
        rvfi[0] = mk(1'b1, 1'b0, 64'd500, 32'h8000_1000, 4'hf, 32'h1);
        rvfi[1] = mk(1'b1, 1'b0, 64'd501, 32'h0, 4'h0, 32'h0);
        tick();
        push2(64'd502, 64'd503);
        check("term_head", tb_if.data.order, 64'd500);
        tb_if.ready = 1'b1;
        tick();
        check("term_pop1", tb_if.data.order, 64'd501);
        check("term_halt1", 64'(halt), 64'd0);
        rvfi[0] = mk(1'b1, 1'b0, 64'd900, 32'h0, 4'h0, 32'h0);
        rvfi[1] = mk(1'b1, 1'b0, 64'd901, 32'h0, 4'h0, 32'h0);
        tick();
        check("term_pop2", tb_if.data.order, 64'd502);
        tick();
        check("term_pop3", tb_if.data.order, 64'd503);
        check("term_halt3", 64'(halt), 64'd0);
        tick();
        check("term_halt", 64'(halt), 64'd1);
        check("term_valid", 64'(tb_if.valid), 64'd0);
        check("term_exit", 64'(exit_code), 64'd1);
        check("term_dropped", 64'(dropped), 64'd0);
        tick();
        idle();
        check("term_halt_hold", 64'(halt), 64'd1);
        check("term_ignored", 64'(tb_if.valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rvfi_commit_serializer

// File: doc/rvfi_commit_serializer.md
RVFI_COMMIT_SERIALIZER -- requirements
Module: rvfi_commit_serializer

Interface
REQ-001 SHALL have parameter NR_COMMIT_PORTS, default 2, number of RVFI commit ports sampled per cycle.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, record buffer entries; power of two, >= NR_COMMIT_PORTS.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rvfi_i  input  NR_COMMIT_PORTS x rvfi_pkg::rvfi_instr_t  commit records; port 0 oldest in program order.
REQ-006 SHALL have port tohost_addr_i  input  riscv::XLEN  tohost address; 0 disables termination detection.
REQ-007 SHALL have port trace_valid_o  output  1  head record available.
REQ-008 SHALL have port trace_ready_i  input  1  consumer accepts head this cycle.
REQ-009 SHALL have port trace_o  output  rvfi_pkg::rvfi_instr_t  head record.
REQ-010 SHALL have port trace_port_o  output  $clog2(NR_COMMIT_PORTS) (min 1)  originating commit port of head.
REQ-011 SHALL have port overflow_o  output  1  sticky; set on any dropped cycle.
REQ-012 SHALL have port dropped_cnt_o  output  32  dropped records, saturating at 0xFFFF_FFFF.
REQ-013 SHALL have port halt_o  output  1  termination reached, FIFO drained.
REQ-014 SHALL have port exit_code_o  output  riscv::XLEN  mem_wdata of terminating store.

Function
REQ-015 SHALL treat port i as pushing when rvfi_i[i].valid or rvfi_i[i].trap; n = number of pushing ports this cycle.
REQ-016 SHALL write pushing records into FIFO in ascending port order, contiguous, within one cycle.
REQ-017 SHALL accept a cycle's pushes all-or-nothing: accept iff count - pop + n <= FIFO_DEPTH, pop = trace_valid_o & trace_ready_i same cycle.
REQ-018 SHALL on rejection drop all n records, set overflow_o, add n to dropped_cnt_o (saturating).
REQ-019 SHALL assert trace_valid_o iff count != 0; trace_o/trace_port_o stable while valid and not ready.
REQ-020 SHALL give one-cycle latency: record pushed at edge N is at head no earlier than after edge N+1.
REQ-021 SHALL pop exactly one record per trace_valid_o & trace_ready_i; read/write pointers wrap modulo FIFO_DEPTH.
REQ-022 SHALL run FSM RUN -> DRAIN -> HALT; HALT terminal until reset.
REQ-023 SHALL in RUN, on a popped record with valid=1, mem_addr == tohost_addr_i != 0, mem_wmask != 0, mem_wdata[0] = 1: latch exit_code_o = mem_wdata, go DRAIN.
REQ-024 SHALL in DRAIN/HALT ignore new commits (not pushed, not counted as dropped) and keep popping.
REQ-025 SHALL go DRAIN -> HALT on the edge where count becomes 0; halt_o = 1 only in HALT.
REQ-026 SHALL ignore the termination condition on trap-only records.

Reset
REQ-027 SHALL on rst_ni low clear pointers, count, overflow_o, dropped_cnt_o, exit_code_o, halt_o; FSM to RUN; trace_valid_o = 0.
REQ-028 SHALL discard buffered records on reset mid-operation; trace_o content while invalid is don't-care.

Structure
REQ-029 SHALL take rvfi_instr_t from rvfi_pkg; FSM enum (RUN, DRAIN, HALT) declared in rvfi_pkg.
REQ-030 SHALL place storage in sub-module rvfi_trace_fifo (multi-push, single-pop, parameterised depth/push width).

Verification
REQ-031 Ports 0,1 valid same cycle, ready=1 -> port 0 record out first, then port 1 next cycle, trace_port_o 0 then 1.
REQ-032 Ready=0, 2 pushes/cycle for 5 cycles, depth 8 -> cycles 1-4 accepted, cycle 5 dropped, overflow_o=1, dropped_cnt_o=2.
REQ-033 FIFO full (8), ready=1, 1 push same cycle -> accepted, count stays 8, no overflow.
REQ-034 tohost_addr_i=0x8000_1000, store wdata=0x1 popped with 3 entries behind -> 3 more pops, halt_o=1, exit_code_o=0x1.
REQ-035 tohost_addr_i=0 and matching store -> FSM stays RUN, halt_o=0.
REQ-036 rst_ni low with 5 buffered entries -> next cycle trace_valid_o=0, counters 0, FSM RUN.
